video_dram_arb: RTL and testbench
=================================

VIDEO_DRAM_ARB -- requirements
Module: video_dram_arb

Interface
REQ-001 SHALL have parameter RFSH_SLOTS, default 32, the slot count between refresh requests (range 4..255).
REQ-002 SHALL have port clk  in  1  28 MHz system clock, all logic on its rising edge.
REQ-003 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port cend  in  1  one-clk pulse ending the current DRAM slot (slot = interval between cend pulses).
REQ-005 SHALL have port video_go  in  1  video fetch window active.
REQ-006 SHALL have port video_bw  in  2  video bandwidth: 00 none, 01 1/8, 10 1/4, 11 1/2.
REQ-007 SHALL have port video_addr  in  21  video word address.
REQ-008 SHALL have port video_next  out  1  pulse when video_addr is consumed.
REQ-009 SHALL have port video_strobe  out  1  pulse when video_data is valid.
REQ-010 SHALL have port video_data  out  16  video read data.
REQ-011 SHALL have port cpu_req  in  1  CPU access request, level.
REQ-012 SHALL have port cpu_rnw  in  1  1 read, 0 write.
REQ-013 SHALL have port cpu_addr  in  21  CPU word address.
REQ-014 SHALL have port cpu_wrdata  in  16  CPU write data.
REQ-015 SHALL have port cpu_bsel  in  2  byte enables, bit1 = high byte.
REQ-016 SHALL have port cpu_next  out  1  pulse when the CPU request is granted.
REQ-017 SHALL have port cpu_strobe  out  1  pulse when cpu_rddata is valid (reads only).
REQ-018 SHALL have port cpu_rddata  out  16  CPU read data.
REQ-019 SHALL have ports dram_req/dram_rnw/dram_rfsh  out  1 each, dram_addr  out  21, dram_wrdata  out  16, dram_bsel  out  2  DRAM command for the current slot.
REQ-020 SHALL have port dram_rddata  in  16  DRAM read data, valid on the clk where cend=1.

Function
REQ-021 SHALL keep a 3-bit slot phase counter, incremented on every clk with cend=1, wrapping 7->0.
REQ-022 A slot SHALL be video-reserved when video_go=1 and (bw=01: phase==0; bw=10: phase[1:0]==0; bw=11: phase[0]==0; bw=00: never). Phase is the value after the increment.
REQ-023 On each clk with cend=1, SHALL select the next slot owner: video if reserved; else refresh if urgent; else CPU if cpu_req; else refresh if pending; else idle.
REQ-024 Refresh: slot counter reaching RFSH_SLOTS SHALL reload to 0 and increment a 2-bit pending count (saturating at 3); pending = count>=1; urgent = count>=2; each refresh slot decrements the count.
REQ-025 Selection SHALL register on the clk edge following the cend clk; dram_* outputs SHALL hold constant for the whole slot.
REQ-026 Video slot: dram_req=1, dram_rnw=1, dram_bsel=11, dram_addr=video_addr; video_next SHALL pulse 1 clk, in the first clk of the slot.
REQ-027 CPU slot: dram_req=1 with cpu_rnw/addr/wrdata/bsel copied; cpu_next SHALL pulse 1 clk, in the first clk of the slot.
REQ-028 Refresh slot: dram_req=1, dram_rfsh=1, dram_rnw=1; idle slot: dram_req=0, dram_rfsh=0.
REQ-029 Read data SHALL be captured from dram_rddata on the cend clk that ends a read slot; the matching *_strobe SHALL pulse 1 clk on the next clk, with *_data valid in that clk and held until the next capture.
REQ-030 Write slots SHALL produce no strobe; a refresh or idle slot SHALL produce no strobe.
REQ-031 A change of video_go or video_bw mid-slot SHALL affect only the next selection; there SHALL be no preemption of a running slot.
REQ-032 When cpu_req is held after a grant, it SHALL be treated as a new request (one grant per slot max).
REQ-033 While a reserved slot has video_go=0, the slot SHALL fall through to CPU/refresh/idle.

Reset
REQ-034 rst_n=0 SHALL immediately clear phase, refresh counter, pending count, all *_next, *_strobe, dram_req, dram_rfsh, dram_rnw (0), dram_addr, dram_wrdata, dram_bsel, video_data and cpu_rddata to 0.
REQ-035 An in-flight read at reset SHALL be discarded (no strobe after release); the first selection SHALL occur on the first cend after rst_n rises.

Verification
REQ-036 bw=10, video_go=1, cpu_req=1 constant, 8 slots -> video owns phases 0,4; CPU owns the other 6; 2 video_next + 6 cpu_next.
REQ-037 Video read with dram_rddata=16'hA55A at the ending cend -> video_strobe=1 for 1 clk after that cend, with video_data=16'hA55A.
REQ-038 RFSH_SLOTS=4, cpu_req=1 continuous, video_go=0 -> refresh is deferred until pending=2, then a refresh slot wins over the CPU; there are never 2 consecutive refresh-starved urgent periods.
REQ-039 CPU write, bsel=01, wrdata=16'h1234 -> dram_rnw=0, dram_bsel=01, dram_wrdata=16'h1234 for the full slot; no cpu_strobe.
REQ-040 Assert rst_n=0 mid-read slot -> outputs 0 asynchronously; no strobe after release; phase restarts at 1 on the first cend.
REQ-041 bw=11 with video_go dropping mid-slot at phase 2 -> the running slot completes; phase 4 goes to CPU/idle.

Source files
------------

// File: rtl/video_dram_arb.sv
// Slot-based DRAM arbiter sharing one DRAM between video fetch, CPU and refresh.
// Each slot ends on cend; the owner of the following slot is registered on that edge.
module video_dram_arb #(
    parameter int RFSH_SLOTS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cend,
    input  logic        video_go,
    input  logic [1:0]  video_bw,
    input  logic [20:0] video_addr,
    output logic        video_next,
    output logic        video_strobe,
    output logic [15:0] video_data,
    input  logic        cpu_req,
    input  logic        cpu_rnw,
    input  logic [20:0] cpu_addr,
    input  logic [15:0] cpu_wrdata,
    input  logic [1:0]  cpu_bsel,
    output logic        cpu_next,
    output logic        cpu_strobe,
    output logic [15:0] cpu_rddata,
    output logic        dram_req,
    output logic        dram_rnw,
    output logic        dram_rfsh,
    output logic [20:0] dram_addr,
    output logic [15:0] dram_wrdata,
    output logic [1:0]  dram_bsel,
    input  logic [15:0] dram_rddata
);

    typedef enum logic [1:0] {
        OWN_IDLE,
        OWN_VID,
        OWN_CPU,
        OWN_RFSH
    } own_t;

    own_t        r_own;
    own_t        w_own;
    logic [2:0]  r_phase;
    logic [2:0]  w_phase;
    logic [7:0]  r_rcnt;
    logic [7:0]  w_rcnt;
    logic [1:0]  r_pend;
    logic [1:0]  w_pend;
    logic [2:0]  w_psum;
    logic        w_resv;
    logic        w_wrap;
    logic        w_dec;

    logic        w_req;
    logic        w_rnw;
    logic        w_rfsh;
    logic [20:0] w_addr;
    logic [15:0] w_wdata;
    logic [1:0]  w_bsel;

    logic        r_video_next;
    logic        r_video_strobe;
    logic [15:0] r_video_data;
    logic        r_cpu_next;
    logic        r_cpu_strobe;
    logic [15:0] r_cpu_rddata;
    logic        r_dram_req;
    logic        r_dram_rnw;
    logic        r_dram_rfsh;
    logic [20:0] r_dram_addr;
    logic [15:0] r_dram_wrdata;
    logic [1:0]  r_dram_bsel;

    always_comb begin
        w_phase = r_phase + 3'd1;
        w_resv  = 1'b0;
        case (video_bw)
            2'b01:   w_resv = (w_phase == 3'd0);
            2'b10:   w_resv = (w_phase[1:0] == 2'd0);
            2'b11:   w_resv = ~w_phase[0];
            default: w_resv = 1'b0;
        endcase
        w_resv = w_resv & video_go;

        // urgent refresh beats the CPU, a merely pending one only fills idle slots
        if (w_resv)
            w_own = OWN_VID;
        else if (r_pend >= 2'd2)
            w_own = OWN_RFSH;
        else if (cpu_req)
            w_own = OWN_CPU;
        else if (r_pend != 2'd0)
            w_own = OWN_RFSH;
        else
            w_own = OWN_IDLE;

        w_wrap = (r_rcnt == 8'(RFSH_SLOTS - 1));
        w_rcnt = w_wrap ? 8'd0 : r_rcnt + 8'd1;
        w_dec  = (w_own == OWN_RFSH);
        w_psum = {1'b0, r_pend} + {2'b00, w_wrap} - {2'b00, w_dec};
        w_pend = (w_psum > 3'd3) ? 2'd3 : w_psum[1:0];

        w_req   = 1'b0;
        w_rnw   = 1'b0;
        w_rfsh  = 1'b0;
        w_addr  = '0;
        w_wdata = '0;
        w_bsel  = '0;
        unique case (w_own)
            OWN_VID: begin
                w_req  = 1'b1;
                w_rnw  = 1'b1;
                w_bsel = 2'b11;
                w_addr = video_addr;
            end
            OWN_CPU: begin
                w_req   = 1'b1;
                w_rnw   = cpu_rnw;
                w_addr  = cpu_addr;
                w_wdata = cpu_wrdata;
                w_bsel  = cpu_bsel;
            end
            OWN_RFSH: begin
                w_req  = 1'b1;
                w_rnw  = 1'b1;
                w_rfsh = 1'b1;
            end
            default: begin
                w_req = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_own          <= OWN_IDLE;
            r_phase        <= '0;
            r_rcnt         <= '0;
            r_pend         <= '0;
            r_video_next   <= 1'b0;
            r_video_strobe <= 1'b0;
            r_video_data   <= '0;
            r_cpu_next     <= 1'b0;
            r_cpu_strobe   <= 1'b0;
            r_cpu_rddata   <= '0;
            r_dram_req     <= 1'b0;
            r_dram_rnw     <= 1'b0;
            r_dram_rfsh    <= 1'b0;
            r_dram_addr    <= '0;
            r_dram_wrdata  <= '0;
            r_dram_bsel    <= '0;
        end else begin
            r_video_next   <= 1'b0;
            r_cpu_next     <= 1'b0;
            r_video_strobe <= 1'b0;
            r_cpu_strobe   <= 1'b0;
            if (cend) begin
                // read data of the slot that is ending
                if (r_own == OWN_VID) begin
                    r_video_data   <= dram_rddata;
                    r_video_strobe <= 1'b1;
                end
                if (r_own == OWN_CPU && r_dram_rnw) begin
                    r_cpu_rddata <= dram_rddata;
                    r_cpu_strobe <= 1'b1;
                end
                r_own         <= w_own;
                r_phase       <= w_phase;
                r_rcnt        <= w_rcnt;
                r_pend        <= w_pend;
                r_video_next  <= (w_own == OWN_VID);
                r_cpu_next    <= (w_own == OWN_CPU);
                r_dram_req    <= w_req;
                r_dram_rnw    <= w_rnw;
                r_dram_rfsh   <= w_rfsh;
                r_dram_addr   <= w_addr;
                r_dram_wrdata <= w_wdata;
                r_dram_bsel   <= w_bsel;
            end
        end
    end

    assign video_next   = r_video_next;
    assign video_strobe = r_video_strobe;
    assign video_data   = r_video_data;
    assign cpu_next     = r_cpu_next;
    assign cpu_strobe   = r_cpu_strobe;
    assign cpu_rddata   = r_cpu_rddata;
    assign dram_req     = r_dram_req;
    assign dram_rnw     = r_dram_rnw;
    assign dram_rfsh    = r_dram_rfsh;
    assign dram_addr    = r_dram_addr;
    assign dram_wrdata  = r_dram_wrdata;
    assign dram_bsel    = r_dram_bsel;

endmodule

// File: tb/tb_video_dram_arb.sv
// Bench for video_dram_arb: two instances (default and short refresh period)
// against a slot-level reference model, plus directed scenario checks.
module tb_video_dram_arb;

    typedef struct packed {
        logic        vnext;
        logic        vstb;
        logic [15:0] vdata;
        logic        cnext;
        logic        cstb;
        logic [15:0] cdata;
        logic        req;
        logic        rnw;
        logic        rfsh;
        logic [20:0] addr;
        logic [15:0] wdata;
        logic [1:0]  bsel;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cend = 1'b0;
    logic        video_go = 1'b0;
    logic [1:0]  video_bw = 2'b00;
    logic [20:0] video_addr = '0;
    logic        cpu_req = 1'b0;
    logic        cpu_rnw = 1'b1;
    logic [20:0] cpu_addr = '0;
    logic [15:0] cpu_wrdata = '0;
    logic [1:0]  cpu_bsel = 2'b00;
    logic [15:0] dram_rddata = '0;

    logic        d_vnext [2];
    logic        d_vstb  [2];
    logic [15:0] d_vdata [2];
    logic        d_cnext [2];
    logic        d_cstb  [2];
    logic [15:0] d_cdata [2];
    logic        d_req   [2];
    logic        d_rnw   [2];
    logic        d_rfsh  [2];
    logic [20:0] d_addr  [2];
    logic [15:0] d_wdata [2];
    logic [1:0]  d_bsel  [2];
    obs_t        o       [2];

    int n_checks = 0;
    int n_err = 0;
    int cnt_vn [2];
    int cnt_cn [2];
    int cnt_rf [2];
    bit force_rd = 1'b0;

    // reference model state: slot phase, slots since last request, backlog, owner
    int   m_ph    [2];
    int   m_since [2];
    int   m_pend  [2];
    int   m_own   [2];
    int   m_nrf   [2];
    obs_t m_exp   [2];

    always #5 clk = ~clk;

    video_dram_arb u_dut (
        .clk(clk), .rst_n(rst_n), .cend(cend),
        .video_go(video_go), .video_bw(video_bw), .video_addr(video_addr),
        .video_next(d_vnext[0]), .video_strobe(d_vstb[0]),
        .video_data(d_vdata[0]),
        .cpu_req(cpu_req), .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr),
        .cpu_wrdata(cpu_wrdata), .cpu_bsel(cpu_bsel),
        .cpu_next(d_cnext[0]), .cpu_strobe(d_cstb[0]),
        .cpu_rddata(d_cdata[0]),
        .dram_req(d_req[0]), .dram_rnw(d_rnw[0]), .dram_rfsh(d_rfsh[0]),
        .dram_addr(d_addr[0]), .dram_wrdata(d_wdata[0]),
        .dram_bsel(d_bsel[0]), .dram_rddata(dram_rddata)
    );

    video_dram_arb #(.RFSH_SLOTS(4)) u_rf (
        .clk(clk), .rst_n(rst_n), .cend(cend),
        .video_go(video_go), .video_bw(video_bw), .video_addr(video_addr),
        .video_next(d_vnext[1]), .video_strobe(d_vstb[1]),
        .video_data(d_vdata[1]),
        .cpu_req(cpu_req), .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr),
        .cpu_wrdata(cpu_wrdata), .cpu_bsel(cpu_bsel),
        .cpu_next(d_cnext[1]), .cpu_strobe(d_cstb[1]),
        .cpu_rddata(d_cdata[1]),
        .dram_req(d_req[1]), .dram_rnw(d_rnw[1]), .dram_rfsh(d_rfsh[1]),
        .dram_addr(d_addr[1]), .dram_wrdata(d_wdata[1]),
        .dram_bsel(d_bsel[1]), .dram_rddata(dram_rddata)
    );

    always_comb begin
        for (int k = 0; k < 2; k++)
            o[k] = {d_vnext[k], d_vstb[k], d_vdata[k], d_cnext[k],
                    d_cstb[k], d_cdata[k], d_req[k], d_rnw[k], d_rfsh[k],
                    d_addr[k], d_wdata[k], d_bsel[k]};
    end

    task automatic chk(input string tag, input logic [77:0] ob,
                       input logic [77:0] ex);
        n_checks++;
        assert (ob === ex) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, ob, ex);
        end
    endtask

    task automatic model_reset(input int k);
        m_ph[k]    = 0;
        m_since[k] = 0;
        m_pend[k]  = 0;
        m_own[k]   = 0;
        m_exp[k]   = '0;
    endtask

    task automatic model_step(input int k);
        obs_t e;
        bit   resv;
        bit   inc;
        int   own;
        int   per;
        e = m_exp[k];
        e.vnext = 1'b0;
        e.cnext = 1'b0;
        e.vstb  = 1'b0;
        e.cstb  = 1'b0;
        if (cend) begin
            if (m_own[k] == 1) begin
                e.vdata = dram_rddata;
                e.vstb  = 1'b1;
            end
            if (m_own[k] == 2 && e.rnw) begin
                e.cdata = dram_rddata;
                e.cstb  = 1'b1;
            end
            m_ph[k] = (m_ph[k] + 1) % 8;
            per = 16 >> video_bw;
            resv = video_go && (video_bw != 2'b00) && (m_ph[k] % per == 0);
            if (resv) own = 1;
            else if (m_pend[k] >= 2) own = 3;
            else if (cpu_req) own = 2;
            else if (m_pend[k] >= 1) own = 3;
            else own = 0;
            m_since[k]++;
            inc = (m_since[k] == ((k == 0) ? 32 : 4));
            if (inc) m_since[k] = 0;
            m_pend[k] = m_pend[k] + int'(inc) - int'(own == 3);
            if (m_pend[k] > 3) m_pend[k] = 3;
            if (own == 3) m_nrf[k]++;
            m_own[k] = own;
            e.vnext = (own == 1);
            e.cnext = (own == 2);
            e.req   = (own != 0);
            e.rfsh  = (own == 3);
            e.rnw   = (own == 1) || (own == 3) || (own == 2 && cpu_rnw);
            e.addr  = (own == 1) ? video_addr : (own == 2) ? cpu_addr : '0;
            e.wdata = (own == 2) ? cpu_wrdata : '0;
            e.bsel  = (own == 1) ? 2'b11 : (own == 2) ? cpu_bsel : 2'b00;
        end
        m_exp[k] = e;
    endtask

    task automatic tick();
        if (!force_rd) dram_rddata = 16'($urandom);
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) model_reset(k);
            else model_step(k);
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("model_u%0d", k), o[k], m_exp[k]);
            cnt_vn[k] += int'(d_vnext[k]);
            cnt_cn[k] += int'(d_cnext[k]);
            if (cend && d_rfsh[k]) cnt_rf[k]++;
        end
    endtask

    task automatic slot(input int len);
        cend = 1'b0;
        for (int i = 0; i < len - 1; i++) tick();
        cend = 1'b1;
        tick();
        cend = 1'b0;
    endtask

    initial begin : main
        bit found;
        int guard;
        for (int k = 0; k < 2; k++) begin
            model_reset(k);
            m_nrf[k]  = 0;
            cnt_vn[k] = 0;
            cnt_cn[k] = 0;
            cnt_rf[k] = 0;
        end

        // reset state
        @(negedge clk);
        tick();
        tick();
        for (int k = 0; k < 2; k++) chk("reset_zero", o[k], '0);
        rst_n = 1'b1;

        // bw=1/4 with a constant CPU request: 2 video + 6 CPU grants
        video_go = 1'b1;
        video_bw = 2'b10;
        cpu_req  = 1'b1;
        cpu_rnw  = 1'b1;
        cnt_vn[0] = 0;
        cnt_cn[0] = 0;
        for (int s = 0; s < 8; s++) begin
            video_addr = 21'($urandom);
            cpu_addr   = 21'($urandom);
            slot($urandom_range(1, 4));
        end
        chk("bw10_video_next_count", 78'(cnt_vn[0]), 78'(2));
        chk("bw10_cpu_next_count", 78'(cnt_cn[0]), 78'(6));

        // video read data capture
        found = 1'b0;
        for (int g = 0; g < 8 && !found; g++) begin
            slot(2);
            found = d_vnext[0];
        end
        chk("video_slot_found", 78'(found), 78'(1));
        force_rd = 1'b1;
        dram_rddata = 16'hA55A;
        slot(3);
        chk("video_strobe_data", 78'({d_vstb[0], d_vdata[0]}),
            78'({1'b1, 16'hA55A}));
        force_rd = 1'b0;
        tick();
        chk("video_strobe_1clk", 78'({d_vstb[0], d_vdata[0]}),
            78'({1'b0, 16'hA55A}));

        // CPU write held for the whole slot, no strobe
        video_go   = 1'b0;
        cpu_req    = 1'b1;
        cpu_rnw    = 1'b0;
        cpu_bsel   = 2'b01;
        cpu_wrdata = 16'h1234;
        cpu_addr   = 21'($urandom);
        found = 1'b0;
        for (int g = 0; g < 4 && !found; g++) begin
            slot(1);
            found = d_cnext[0];
        end
        chk("cpu_wr_found", 78'(found), 78'(1));
        chk("cpu_wr_clk0", 78'({d_rnw[0], d_bsel[0], d_wdata[0]}),
            78'({1'b0, 2'b01, 16'h1234}));
        cpu_wrdata = 16'hBEEF;
        cpu_bsel   = 2'b10;
        for (int j = 1; j < 3; j++) begin
            tick();
            chk($sformatf("cpu_wr_clk%0d", j),
                78'({d_rnw[0], d_bsel[0], d_wdata[0]}),
                78'({1'b0, 2'b01, 16'h1234}));
        end
        cend = 1'b1;
        tick();
        cend = 1'b0;
        chk("cpu_wr_no_strobe", 78'(d_cstb[0]), 78'(0));

        // short refresh period under continuous CPU demand
        cnt_rf[1] = 0;
        m_nrf[1]  = 0;
        for (int s = 0; s < 40; s++) begin
            cpu_rnw    = 1'($urandom);
            cpu_addr   = 21'($urandom);
            cpu_wrdata = 16'($urandom);
            cpu_bsel   = 2'($urandom);
            slot($urandom_range(1, 4));
        end
        chk("rfsh_count_model", 78'(cnt_rf[1]), 78'(m_nrf[1]));
        chk("rfsh_count_range",
            78'(cnt_rf[1] >= 8 && cnt_rf[1] <= 12), 78'(1));

        // randomized traffic with mid-slot video_go/video_bw changes
        for (int s = 0; s < 60; s++) begin
            int len;
            video_go   = 1'($urandom);
            video_bw   = 2'($urandom);
            video_addr = 21'($urandom);
            cpu_req    = 1'($urandom);
            cpu_rnw    = 1'($urandom);
            cpu_addr   = 21'($urandom);
            cpu_wrdata = 16'($urandom);
            cpu_bsel   = 2'($urandom);
            len = $urandom_range(1, 4);
            cend = 1'b0;
            for (int i = 0; i < len - 1; i++) begin
                if ($urandom_range(0, 2) == 0) video_go = ~video_go;
                if ($urandom_range(0, 2) == 0) video_bw = 2'($urandom);
                tick();
            end
            cend = 1'b1;
            tick();
            cend = 1'b0;
        end

        // bw=1/2, video_go drops during the phase-2 video slot
        video_go = 1'b1;
        video_bw = 2'b11;
        cpu_req  = 1'b1;
        cpu_rnw  = 1'b1;
        guard = 0;
        while (m_ph[0] != 1 && guard < 10) begin
            slot(1);
            guard++;
        end
        chk("reach_phase1", 78'(guard < 10), 78'(1));
        video_addr = 21'h0ABCDE;
        slot(1);
        chk("ph2_video_next", 78'(d_vnext[0]), 78'(1));
        tick();
        video_go = 1'b0;
        tick();
        chk("ph2_slot_held", 78'({d_req[0], d_rnw[0], d_addr[0]}),
            78'({1'b1, 1'b1, 21'h0ABCDE}));
        cend = 1'b1;
        tick();
        cend = 1'b0;
        chk("ph2_video_strobe", 78'(d_vstb[0]), 78'(1));
        slot(2);
        chk("ph4_no_video", 78'({d_vnext[0], d_cnext[0]}), 78'(2'b01));

        // reset in the middle of a video read slot
        video_go = 1'b1;
        video_bw = 2'b11;
        cpu_req  = 1'b0;
        found = 1'b0;
        for (int g = 0; g < 4 && !found; g++) begin
            slot(1);
            found = d_vnext[0];
        end
        chk("rst_video_found", 78'(found), 78'(1));
        tick();
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("async_rst_u%0d", k), o[k], '0);
            model_reset(k);
        end
        cend = 1'b1;
        tick();
        cend = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_no_strobe", 78'(d_vstb[0]), 78'(0));
        slot(2);
        chk("rst_phase1", 78'({d_vnext[0], d_vstb[0]}), 78'(0));
        slot(2);
        chk("rst_phase2", 78'(d_vnext[0]), 78'(1));

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end

endmodule
